// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner
// Conditions the raw board switches for the control decoder. Each bit goes
// through a two-flop synchronizer and is then debounced by its own counter.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive sampled
// mismatches. An accepted change raises a one-cycle rise or fall pulse.
//
// Ports:
//   clk        board clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw_raw     raw asynchronous switch pins
//   sw_level   debounced switch levels (registered)
//   sw_rise    one-cycle 0->1 pulse per bit (registered)
//   sw_fall    one-cycle 1->0 pulse per bit (registered)
//   sw_event   OR of all rise/fall pulses (combinational from registers)
//   glitch_cnt saturating count of edges with an aborted debounce run
//              (port exists only when SW_GLITCH_CNT_EN is defined)
//
// Optional feature macro: SW_GLITCH_CNT_EN
module sw_input_conditioner #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_event
`ifdef SW_GLITCH_CNT_EN
    ,
    output logic [15:0]      glitch_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            level_d;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_d;

    // Two-flop synchronizer; the only reader of sw_raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: count consecutive mismatches, accept at CNT_MAX.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = sw_level;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2[i] == sw_level[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]   = '0;
                level_d[i] = sync2[i];
                rise_d[i]  = sync2[i];
                fall_d[i]  = ~sync2[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sw_level <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sw_level <= level_d;
            sw_rise  <= rise_d;
            sw_fall  <= fall_d;
        end
    end

    // Pulses are already registered, so the summary adds no latency.
    assign sw_event = |(sw_rise | sw_fall);

`ifdef SW_GLITCH_CNT_EN
    logic [WIDTH-1:0] cnt_nz;
    logic             any_abort;

    // A run aborts when sync2 returns to the level while its counter is live.
    always_comb begin
        cnt_nz = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_nz[i] = |cnt_q[i];
        end
        any_abort = |(~(sync2 ^ sw_level) & cnt_nz);
    end

    // One count per edge regardless of how many bits abort; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (any_abort && (glitch_cnt != 16'hFFFF)) begin
            glitch_cnt <= glitch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Self-checking bench for sw_input_conditioner (WIDTH=16, DEBOUNCE_CYCLES=4).
// A reference model keeps a history of the sampled switch values and accepts
// a new level when the last N compared samples all differ from the level.
module tb_sw_input_conditioner;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw_raw = 16'h0;
    logic [15:0] sw_level;
    logic [15:0] sw_rise;
    logic [15:0] sw_fall;
    logic        sw_event;
`ifdef SW_GLITCH_CNT_EN
    logic [15:0] glitch_cnt;
`endif

    sw_input_conditioner #(
        .WIDTH          (16),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_level  (sw_level),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_event  (sw_event)
`ifdef SW_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] raw_hist[$];
    logic [15:0] cmp_hist[$];
    logic [15:0] m_level, m_rise, m_fall;
    logic [15:0] prev_run;
    int          m_glitch;

    task automatic model_reset();
        raw_hist.delete();
        raw_hist.push_back(16'h0);
        raw_hist.push_back(16'h0);
        cmp_hist.delete();
        m_level  = '0;
        m_rise   = '0;
        m_fall   = '0;
        prev_run = '0;
        m_glitch = 0;
    endtask

    task automatic model_step(input logic [15:0] raw);
        logic [15:0] cmp, flip, mm;
        // Value seen by the debounce logic is the raw sample two edges old.
        cmp = raw_hist[raw_hist.size() - 2];
        raw_hist.push_back(raw);
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        cmp_hist.push_back(cmp);
        if (cmp_hist.size() > N) void'(cmp_hist.pop_front());
        flip = '0;
        if (cmp_hist.size() == N) begin
            flip = '1;
            foreach (cmp_hist[j]) flip &= (cmp_hist[j] ^ m_level);
        end
        mm = cmp ^ m_level;
        if (|(~mm & prev_run) && m_glitch < 16'hFFFF) m_glitch++;
        prev_run = mm & ~flip;
        m_level  = m_level ^ flip;
        m_rise   = flip & m_level;
        m_fall   = flip & ~m_level;
    endtask

    // One clock edge: advance the model, then compare away from the edge.
    task automatic tick();
        @(posedge clk);
        model_step(sw_raw);
        #1;
        chk("level", sw_level, m_level);
        chk("rise",  sw_rise,  m_rise);
        chk("fall",  sw_fall,  m_fall);
        chk("event", sw_event, |(m_rise | m_fall));
`ifdef SW_GLITCH_CNT_EN
        chk("glitch", glitch_cnt, m_glitch);
`endif
    endtask

    task automatic do_reset(input logic [15:0] raw);
        rst_n  = 1'b0;
        sw_raw = raw;
        model_reset();
        #1;
        chk("rst_level", sw_level, 16'h0);
        chk("rst_rise",  sw_rise,  16'h0);
        chk("rst_fall",  sw_fall,  16'h0);
        chk("rst_event", sw_event, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] raw;
        logic [15:0] level;
        logic [15:0] rise;
        logic [15:0] fall;
        logic        ev;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int          ev_cnt;
        logic [15:0] cur;

        // Power-up of bit 0: level after edge 5, single rise pulse.
        tbl[0] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[2] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[3] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b1};
        tbl[6] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0};

        #2;
        do_reset(16'h0000);
        foreach (tbl[i]) begin
            sw_raw = tbl[i].raw;
            tick();
            chk("tbl_level", sw_level, tbl[i].level);
            chk("tbl_rise",  sw_rise,  tbl[i].rise);
            chk("tbl_fall",  sw_fall,  tbl[i].fall);
            chk("tbl_event", sw_event, tbl[i].ev);
        end

        // Short low glitch on bit 0 is rejected.
        sw_raw = 16'h0000;
        repeat (2) tick();
        sw_raw = 16'h0001;
        ev_cnt = 0;
        repeat (8) begin
            tick();
            if (sw_event) ev_cnt++;
        end
        chk("glitch_level", sw_level, 16'h0001);
        chk("glitch_no_event", ev_cnt, 0);
`ifdef SW_GLITCH_CNT_EN
        chk("glitch_cnt_one", glitch_cnt, 16'd1);
`endif

        // Two bits fall together, then rise together.
        sw_raw = 16'h8001;
        repeat (8) tick();
        chk("two_up_level", sw_level, 16'h8001);
        sw_raw = 16'h0000;
        ev_cnt = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (sw_event) ev_cnt++;
            if (t == 6) chk("two_fall", sw_fall, 16'h8001);
        end
        chk("two_fall_events", ev_cnt, 1);
        chk("two_fall_level", sw_level, 16'h0000);
        sw_raw = 16'h8001;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 6) chk("two_rise", sw_rise, 16'h8001);
        end

        // Bit 3 chatters, then holds high; rise lands five edges later.
        sw_raw = 16'h0000;
        repeat (8) tick();
        for (int t = 0; t < 50; t++) begin
            sw_raw = (t % 2 == 0) ? 16'h0008 : 16'h0000;
            tick();
            chk("chatter_quiet", sw_event, 1'b0);
        end
        sw_raw = 16'h0008;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("hold_rise", sw_rise, (t == 6) ? 16'h0008 : 16'h0000);
        end
`ifdef SW_GLITCH_CNT_EN
        chk("chatter_glitch_nz", (glitch_cnt != 16'd0), 1'b1);
`endif

        // Reset lands on the third mismatch edge of a bit-5 run.
        sw_raw = 16'h0028;
        repeat (5) tick();
        chk("pre_rst_level", sw_level, 16'h0008);
        do_reset(16'h0028);
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("post_rst_bit5", sw_level[5], (t == 6));
        end

        // Release reset with every switch already high.
        do_reset(16'hFFFF);
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("all_level", sw_level, (t >= 6) ? 16'hFFFF : 16'h0000);
            chk("all_rise",  sw_rise,  (t == 6) ? 16'hFFFF : 16'h0000);
        end

        // Random per-bit chatter against the model, with one reset midway.
        cur = sw_raw;
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                do_reset(cur);
            end
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            end
            sw_raw = cur;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_input_conditioner.md
# sw_input_conditioner

Synchronizes, debounces and edge-detects the board slide switches before they reach the control-decode logic. It sits between the raw `SW[15:0]` pins and the switch decoder that produces run/pause/reset and display-select controls. It presents clean levels and single-cycle rise/fall event pulses, so downstream logic never sees metastable or bouncing inputs.

## Interface
Parameters:
- `WIDTH`, 16: number of switch bits conditioned.
- `DEBOUNCE_CYCLES`, 100000: consecutive stable clock cycles required to accept a new level (1 ms at 100 MHz). Must be ≥ 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: per-bit counter width (localparam).

Ports:
- `clk`  in  1: board clock. All state is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sw_raw`  in  WIDTH: raw, asynchronous switch pins.
- `sw_level`  out  WIDTH: debounced switch levels.
- `sw_rise`  out  WIDTH: one-cycle pulse when the matching `sw_level` bit goes 0→1.
- `sw_fall`  out  WIDTH: one-cycle pulse when the matching `sw_level` bit goes 1→0.
- `sw_event`  out  1: OR of all `sw_rise` and `sw_fall` bits in the same cycle.
- `glitch_cnt`  out  16: rejected-bounce count. Present only with `SW_GLITCH_CNT_EN`.

## Operation
- Reset: sync stages, counters, `sw_level`, `sw_rise`, `sw_fall`, `sw_event` and `glitch_cnt` all clear to 0 immediately and asynchronously.
- Synchronizer: each bit passes through a two-flop chain, `sync1` then `sync2`. No other logic reads `sw_raw`.
- Per-bit counter behaviour on each edge, for each bit i:
  - `sync2[i] == sw_level[i]`: the counter clears to 0. If the counter was nonzero, an aborted run is recorded as a glitch.
  - `sync2[i] != sw_level[i]` and counter < `DEBOUNCE_CYCLES-1`: the counter increments.
  - `sync2[i] != sw_level[i]` and counter == `DEBOUNCE_CYCLES-1`: `sw_level[i]` takes `sync2[i]`, the counter clears, and the matching `sw_rise[i]` or `sw_fall[i]` is set for exactly one cycle.
- Bits are fully independent. Several bits may flip, and pulse, in the same cycle.
- Pulses are registered outputs that last one cycle. A new run cannot complete in the cycle after a flip, so pulses for the same bit are always at least `DEBOUNCE_CYCLES` cycles apart.
- Power-up with a switch already high: `sw_level` rises after the debounce latency and a `sw_rise` pulse is emitted. This is required behaviour: downstream sees the initial state as an event.
- Counter width: `CNT_W` bits. The counter never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.

## Timing
- Let edge k be the first clock edge at which `sync1` samples the new raw value, with the raw value then held stable.
  - `sync2` updates at edge k+1.
  - Mismatch edges run from k+2 to k+1+N, where N = `DEBOUNCE_CYCLES`.
  - `sw_level` and the pulse update at edge k+1+N, which is N+1 edges after sampling.
- Any return of `sync2` to the current level before edge k+1+N restarts the run. The next mismatch needs a full N edges again.
- `rst_n` asserted mid-run: the run is discarded and outputs go to 0 at once.
- After `rst_n` releases, the first sampling edge is the first rising edge with `rst_n` high.
- `sw_event` is combinational from the registered pulses, with zero added latency.

## Configuration
- `SW_GLITCH_CNT_EN` defined:
  - The `glitch_cnt` port exists.
  - It increments by 1 on any edge where at least one bit aborts a nonzero run. This is 1 per edge regardless of how many bits abort.
  - It saturates at 0xFFFF and clears on reset.
- `SW_GLITCH_CNT_EN` undefined: no port and no counter logic. Debounce behaviour is identical.

## Test plan
All scenarios use `WIDTH`=16 and `DEBOUNCE_CYCLES`=4.
- Reset with `sw_raw`=0x0000, release, then drive 0x0001 stably before edge 0. Required: `sw_level`=0x0001 after edge 5, `sw_rise`=0x0001 and `sw_event`=1 for exactly that one cycle, no `sw_fall`.
- Starting at `sw_level`=0x0001, pulse bit 0 low for 2 cycles, then return high. Required: `sw_level` stays 0x0001, no pulses. With the macro, `glitch_cnt` goes 0→1.
- Drive 0x8001 to 0x0000 and 0x0000 to 0x8001 stably in the same cycle. Required: one cycle with `sw_fall`=0x8001, then `sw_level`=0x0000, and a single `sw_event` pulse.
- Toggle bit 3 every cycle for 50 cycles, then hold it high. Required: no pulse during toggling, `sw_rise`=0x0008 five edges after the hold begins. With the macro, `glitch_cnt` is nonzero and saturates when forced past 0xFFFF.
- Assert `rst_n` low at the third mismatch edge of a run on bit 5. Required: all outputs 0 immediately, and after release a full 5-edge latency before `sw_level[5]` rises.
- Reset released with `sw_raw`=0xFFFF. Required: `sw_level`=0xFFFF after edge 5, and `sw_rise`=0xFFFF for one cycle.
